pc_jump_ctrl: RTL
=================

PC_JUMP_CTRL -- requirements
Module: pc_jump_ctrl

Interface
REQ-001 Parameter RESET_VEC, default 16'h0000: value loaded into pc on reset.
REQ-002 Parameter FLUSH_CYCLES, default 1, legal range 1..3: number of squash cycles after a taken jump.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 zr  input  1  zero flag from the upstream 16-bit zero-detect stage; 1 = ALU result is zero.
REQ-006 ng  input  1  sign flag, ALU result bit 15; 1 = negative.
REQ-007 jmp  input  3  jump field {j1,j2,j3} = {jump-if-lt, jump-if-eq, jump-if-gt}.
REQ-008 target  input  16  jump destination address.
REQ-009 flag_valid  input  1  zr, ng, jmp and target are valid this cycle.
REQ-010 stall  input  1  freeze all state this cycle.
REQ-011 pc  output  16  registered program counter.
REQ-012 taken  output  1  registered; one-cycle pulse in the cycle after a jump decision is taken.
REQ-013 flush  output  1  high while the FSM is in FLUSH; downstream squashes the in-flight instruction.
REQ-014 busy  output  1  high while in FLUSH; upstream holds flag_valid low.

Function
REQ-015 cond SHALL be (j1 & ng & ~zr) | (j2 & zr) | (j3 & ~ng & ~zr); jmp=000 never jumps, jmp=111 always jumps.
REQ-016 zr=1 with ng=1 is an illegal input; cond SHALL then depend only on j2.
REQ-017 FSM states: RUN, FLUSH; reset state RUN.
REQ-018 Update priority SHALL be, highest first: reset, stall, taken jump, increment.
REQ-019 stall=1: pc, state, flush counter and taken SHALL hold, with taken forced to 0; a decision presented under stall is not consumed, and upstream re-presents it.
REQ-020 RUN, flag_valid=1, cond=1, no stall: next edge pc<=target, state<=FLUSH, counter<=FLUSH_CYCLES-1, taken<=1.
REQ-021 RUN, flag_valid=1, cond=0, or flag_valid=0, no stall: pc<=pc+1, taken<=0.
REQ-022 FLUSH, no stall: pc holds; flag_valid ignored; counter=0 -> state<=RUN, else counter decrements.
REQ-023 flush SHALL be high for exactly FLUSH_CYCLES unstalled cycles per taken jump.
REQ-024 pc arithmetic is 16-bit modulo: 16'hFFFF+1 -> 16'h0000; target=pc is a legal self-jump.
REQ-025 Decision latency: one cycle from flag_valid sample to pc=target and taken=1.

Reset
REQ-026 rst_n=0 at a rising edge SHALL set pc=RESET_VEC, state=RUN, counter=0, taken=0, flush=0, busy=0, regardless of stall or flag_valid.
REQ-027 Reset asserted mid-FLUSH SHALL abort the flush; first cycle after release is RUN with pc=RESET_VEC.
REQ-028 First increment SHALL occur at the first rising edge with rst_n=1.

Structure
REQ-029 Package pc_jump_pkg SHALL hold the state encoding (RUN=0, FLUSH=1), jmp field bit positions and the 16-bit address width constant.
REQ-030 The condition evaluator SHALL be a separate combinational sub-module, pc_jump_cond (inputs zr, ng, jmp; output cond).
REQ-031 All outputs except flush/busy SHALL be flop outputs; flush/busy decode the registered state only.

Verification
REQ-032 Reset then 4 idle cycles, RESET_VEC=0 -> pc sequence 0,1,2,3,4, taken=0, flush=0.
REQ-033 pc=16'h0010, flag_valid=1, jmp=010, zr=1, target=16'h0100 -> next cycle pc=16'h0100, taken=1, flush=1 for 1 cycle, then pc=16'h0101.
REQ-034 jmp=001, ng=1, zr=0, target=16'h0200 -> not taken, pc increments by 1; jmp=100, same flags -> pc=16'h0200.
REQ-035 FLUSH_CYCLES=3, taken jump, stall=1 in the 2nd flush cycle -> flush high 4 cycles total, pc held at target throughout.
REQ-036 pc=16'hFFFF, no jump -> pc=16'h0000; rst_n=0 during FLUSH -> pc=RESET_VEC, flush=0 next cycle.
REQ-037 flag_valid=1, jmp=111, stall=1 for 2 cycles then 0 -> pc frozen 2 cycles, jump taken on the first unstalled edge.

Source files
------------

// File: rtl/pc_jump_pkg.sv
// Shared constants and types for the program-counter jump controller.
package pc_jump_pkg;

    // Address and counter widths
    localparam int unsigned ADDR_W = 16;
    localparam int unsigned JMP_W  = 3;
    localparam int unsigned CNT_W  = 2;

    // Bit positions inside the jmp field {j1, j2, j3}
    localparam int unsigned JMP_LT_BIT = 2;
    localparam int unsigned JMP_EQ_BIT = 1;
    localparam int unsigned JMP_GT_BIT = 0;

    // Controller state encoding
    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_t;

endpackage : pc_jump_pkg

// File: rtl/pc_jump_cond.sv
// Combinational jump-condition evaluator driven by the ALU zero/sign flags.
module pc_jump_cond
    import pc_jump_pkg::*;
(
    input  logic             zr,
    input  logic             ng,
    input  logic [JMP_W-1:0] jmp,
    output logic             cond
);

    logic is_lt;
    logic is_eq;
    logic is_gt;

    // Classify the ALU result; zr dominates so zr=1,ng=1 behaves as "equal"
    always_comb begin
        is_eq = zr;
        is_lt = ng & ~zr;
        is_gt = ~ng & ~zr;
    end

    // Jump if any requested relation holds
    always_comb begin
        cond = (jmp[JMP_LT_BIT] & is_lt)
             | (jmp[JMP_EQ_BIT] & is_eq)
             | (jmp[JMP_GT_BIT] & is_gt);
    end

endmodule : pc_jump_cond

// File: rtl/pc_jump_ctrl.sv
// Program counter with conditional jump and a fixed-length squash window.
module pc_jump_ctrl
    import pc_jump_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_VEC    = 16'h0000,
    parameter int unsigned       FLUSH_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              zr,
    input  logic              ng,
    input  logic [JMP_W-1:0]  jmp,
    input  logic [ADDR_W-1:0] target,
    input  logic              flag_valid,
    input  logic              stall,
    output logic [ADDR_W-1:0] pc,
    output logic              taken,
    output logic              flush,
    output logic              busy
);

    // Counter load value: the flush window ends when the counter reads zero
    localparam logic [CNT_W-1:0] FLUSH_LAST = CNT_W'(FLUSH_CYCLES - 1);

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_nxt;
    logic [ADDR_W-1:0] pc_nxt;
    logic              taken_nxt;
    logic              cond;

    pc_jump_cond u_cond (
        .zr   (zr),
        .ng   (ng),
        .jmp  (jmp),
        .cond (cond)
    );

    // State, counter, pc and taken registers with synchronous reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= RUN;
            cnt   <= '0;
            pc    <= RESET_VEC;
            taken <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            pc    <= pc_nxt;
            taken <= taken_nxt;
        end
    end

    // Next-state logic: stall freezes everything except taken, which drops
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        pc_nxt    = pc;
        taken_nxt = 1'b0;
        if (!stall) begin
            case (state)
                RUN: begin
                    if (flag_valid && cond) begin
                        pc_nxt    = target;
                        state_nxt = FLUSH;
                        cnt_nxt   = FLUSH_LAST;
                        taken_nxt = 1'b1;
                    end else begin
                        pc_nxt = pc + ADDR_W'(1);
                    end
                end
                FLUSH: begin
                    if (cnt == '0) begin
                        state_nxt = RUN;
                    end else begin
                        cnt_nxt = cnt - CNT_W'(1);
                    end
                end
                default: begin
                    state_nxt = RUN;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    // Squash indicators decode the registered state only
    always_comb begin
        flush = (state == FLUSH);
        busy  = (state == FLUSH);
    end

endmodule : pc_jump_ctrl
